// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared types for the pipelined immediate extender: the fill
//               mode encoding used on in_mode and inside imm_ext_core.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    // Fill modes for the bits above the selected field width
    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_ONES = 2'd2,
        EXT_LSH  = 2'd3
    } ext_mode_t;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Purely combinational immediate extender. Keeps the low w bits
//               of the field and fills the rest with sign / zero / ones, or
//               with the sign-extended value shifted left by LSH.
//               Build macro IMM_EXT_LSH_EN enables the shift mode; without it
//               mode 3 behaves exactly as sign extension and no shifter exists.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 22,
    parameter int OUT_W = 32,
    parameter int LSH   = 2,
    parameter int FW_W  = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  i_data,
    input  logic [FW_W-1:0]  i_fw,
    input  logic [1:0]       i_mode,
    output logic [OUT_W-1:0] o_ext,
    output logic             o_neg
);

    localparam logic [FW_W-1:0] c_in_w = FW_W'(IN_W);

    ext_mode_t        w_mode;
    logic [FW_W-1:0]  w_width;
    logic [OUT_W-1:0] w_data_ext;
    logic [OUT_W-1:0] w_low_mask;
    logic [OUT_W-1:0] w_top_bit;
    logic [OUT_W-1:0] w_base;
    logic             w_sign;
    logic             w_fill;

    // Resolve effective width and build a mask covering the low w bits
    always_comb begin
        w_mode     = ext_mode_t'(i_mode);
        w_width    = ((i_fw == '0) || (i_fw > c_in_w)) ? c_in_w : i_fw;
        w_data_ext = OUT_W'(i_data);
        w_low_mask = ~({OUT_W{1'b1}} << w_width);
        // Highest set bit of the mask selects the field's sign bit without
        // a variable-width index.
        w_top_bit  = w_low_mask & ~(w_low_mask >> 1);
        w_sign     = |(w_data_ext & w_top_bit);
    end

    // Choose the fill bit and merge it above the kept field bits
    always_comb begin
        case (w_mode)
            EXT_ZERO: w_fill = 1'b0;
            EXT_ONES: w_fill = 1'b1;
            default:  w_fill = w_sign;
        endcase
        w_base = (w_data_ext & w_low_mask) | ({OUT_W{w_fill}} & ~w_low_mask);
    end

`ifdef IMM_EXT_LSH_EN
    // Shift mode: sign-extended value moved left, zeros enter at the bottom
    always_comb begin
        o_ext = (w_mode == EXT_LSH) ? (w_base << LSH) : w_base;
        o_neg = w_fill;
    end
`else
    // Mode 3 falls through to sign extension inside the fill selection
    always_comb begin
        o_ext = w_base;
        o_neg = w_fill;
    end
`endif

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Pipelined immediate extender between decode and execute.
//               The extension is computed combinationally on the input beat
//               and stored into a DEPTH-entry FIFO; valid/ready on both sides.
//               in_ready depends only on the stored count, never on out_ready.
//               Build macro IMM_EXT_LSH_EN enables the left-shift fill mode.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 22,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int LSH   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_data,
    input  logic [$clog2(IN_W+1)-1:0]  in_fw,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_neg
);

    localparam int FW_W  = $clog2(IN_W + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [OUT_W-1:0] r_data_mem [DEPTH];
    logic             r_neg_mem  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [OUT_W-1:0] w_ext;
    logic             w_neg;
    logic             w_push;
    logic             w_pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LSH   (LSH),
        .FW_W  (FW_W)
    ) u_core (
        .i_data (in_data),
        .i_fw   (in_fw),
        .i_mode (in_mode),
        .o_ext  (w_ext),
        .o_neg  (w_neg)
    );

    // Handshake qualifiers and head-entry presentation
    always_comb begin
        in_ready  = (r_count != c_depth);
        out_valid = (r_count != '0);
        w_push    = in_valid & in_ready;
        w_pop     = out_valid & out_ready;
        out_data  = r_data_mem[r_rd_ptr];
        out_neg   = r_neg_mem[r_rd_ptr];
    end

    // One storage slot per entry; cleared on reset so outputs read zero
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] c_slot = PTR_W'(gi);

            // Capture the extended beat when the write pointer selects this slot
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data_mem[gi] <= '0;
                    r_neg_mem[gi]  <= 1'b0;
                end else if (w_push && (r_wr_ptr == c_slot)) begin
                    r_data_mem[gi] <= w_ext;
                    r_neg_mem[gi]  <= w_neg;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Occupancy: push and pop in the same cycle leave the count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe (IN_W=22, OUT_W=32,
//               DEPTH=2, LSH=2). Expected results are queued when a beat is
//               accepted and a monitor pops and compares on every output pop.
//               Expectations for mode 3 follow IMM_EXT_LSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    localparam int IN_W  = 22;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;
    localparam int LSH   = 2;

    typedef struct {
        logic [31:0] d;
        logic        n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] in_data;
    logic [4:0]  in_fw;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_neg;

    logic        dir_ready;
    logic        rr_val;
    logic        rr_en;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_errors;

    assign out_ready = rr_en ? rr_val : dir_ready;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .LSH   (LSH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_fw     (in_fw),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: arithmetic on the field value, not bit masks
    function automatic exp_t model(input logic [21:0] d, input int fw, input int mode);
        exp_t   r;
        int     w;
        longint p;
        longint low;
        longint val;
        bit     sgn;
        bit     fill;
        w    = (fw == 0 || fw > IN_W) ? IN_W : fw;
        p    = longint'(1) << w;
        low  = longint'(d) % p;
        sgn  = (low >= p / 2);
        fill = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : sgn;
        val  = fill ? (low + (64'h1_0000_0000 - p)) : low;
`ifdef IMM_EXT_LSH_EN
        if (mode == 3) val = (val * 4) % 64'h1_0000_0000;
`endif
        r.d = val[31:0];
        r.n = fill;
        return r;
    endfunction

    // Present a beat until accepted; queue its expected result on acceptance
    task automatic send(input logic [21:0] d, input logic [4:0] fw, input logic [1:0] m,
                        input logic [31:0] e, input logic n, input int max_cyc);
        bit done;
        int k;
        exp_t x;
        done     = 1'b0;
        k        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_fw    = fw;
        in_mode  = m;
        while (!done && k < max_cyc) begin
            @(negedge clk);
            if (in_ready) begin
                x.d = e;
                x.n = n;
                sb_q.push_back(x);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within %0d cycles", max_cyc);
        end
    endtask

    task automatic send_model(input logic [21:0] d, input logic [4:0] fw, input logic [1:0] m);
        exp_t x;
        x = model(d, int'(fw), int'(m));
        send(d, fw, m, x.d, x.n, 200);
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < max_cyc) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: every pop of the DUT head is compared with the oldest expectation
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got 0x%08h expected no output", out_data);
                end else begin
                    x = sb_q.pop_front();
                    chk("out_data", out_data, x.d);
                    chk("out_neg", 32'(out_neg), 32'(x.n));
                end
            end
        end
    end

    // Random consumer back-pressure while enabled
    initial begin : rand_ready_gen
        rr_val = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rr_val = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        exp_t hx;
        logic [31:0] lsh_exp;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_fw     = '0;
        in_mode   = '0;
        dir_ready = 1'b0;
        rr_en     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_neg", 32'(out_neg), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        dir_ready = 1'b1;
        @(posedge clk);
        #1;

        // Directed extensions with one-cycle latency from an empty buffer
        send(22'h200000, 5'd0, 2'd0, 32'hFFE00000, 1'b1, 10);
        @(negedge clk);
        chk("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        send(22'h200000, 5'd0,  2'd1, 32'h00200000, 1'b0, 10);
        send(22'h3FFF80, 5'd8,  2'd0, 32'hFFFFFF80, 1'b1, 10);
        send(22'h3FFF80, 5'd8,  2'd1, 32'h00000080, 1'b0, 10);
        send(22'h200000, 5'd30, 2'd0, 32'hFFE00000, 1'b1, 10);
        send(22'h1FFFFF, 5'd30, 2'd0, 32'h001FFFFF, 1'b0, 10);
`ifdef IMM_EXT_LSH_EN
        lsh_exp = 32'hFFFFFFFC;
`else
        lsh_exp = 32'hFFFFFFFF;
`endif
        send(22'h3FFFFF, 5'd22, 2'd3, lsh_exp, 1'b1, 10);
        send(22'h000005, 5'd4,  2'd2, 32'hFFFFFFF5, 1'b1, 10);
        drain(20);

        // Back-pressure: A and B fill the buffer, C is held off
        dir_ready = 1'b0;
        send(22'h000011, 5'd8, 2'd1, 32'h00000011, 1'b0, 10);
        send(22'h0000F2, 5'd8, 2'd0, 32'hFFFFFFF2, 1'b1, 10);
        in_valid = 1'b1;
        in_data  = 22'h000033;
        in_fw    = 5'd8;
        in_mode  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("hold_head", out_data, 32'h00000011);
            @(posedge clk);
            #1;
        end
        dir_ready = 1'b1;
        send(22'h000033, 5'd8, 2'd1, 32'h00000033, 1'b0, 10);
        drain(20);

        // Steady push and pop with one entry resident
        send_model(22'h0ABCDE, 5'd12, 2'd0);
        for (int i = 0; i < 10; i++) begin
            chk("ss_in_ready", 32'(in_ready), 32'd1);
            chk("ss_out_valid", 32'(out_valid), 32'd1);
            send_model(22'($urandom), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        drain(20);

        // Randomized traffic under random back-pressure
        rr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send_model(22'($urandom), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        drain(200);
        rr_en = 1'b0;

        // Reset while full drops buffered entries
        dir_ready = 1'b0;
        send(22'h000001, 5'd4, 2'd2, 32'hFFFFFFF1, 1'b1, 10);
        send(22'h000002, 5'd4, 2'd1, 32'h00000002, 1'b0, 10);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_data", out_data, 32'd0);
        dir_ready = 1'b1;
        hx = model(22'h000080, 8, 0);
        send(22'h000080, 5'd8, 2'd0, hx.d, hx.n, 10);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_imm_extend_pipe
`default_nettype wire
